// File: rtl/host_axi_mux.sv
// Host register request router onto NUM_SLAVES AXI-Lite control slaves.
// Optional watchdog enabled by defining HOST_AXI_TIMEOUT_EN.
module host_axi_mux #(
    parameter int NUM_SLAVES         = 2,
    parameter int HOST_ADDR_BITS     = 8,
    parameter int HOST_DATA_BITS     = 32,
    parameter int HOST_AXI_ADDR_BITS = 6,
    parameter int HOST_AXI_DATA_BITS = 32,
    parameter int HOST_AXI_STRB_BITS = HOST_AXI_DATA_BITS / 8,
    parameter int SEL_BITS           = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     host_req_valid,
    input  logic                                     host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0]                host_req_addr,
    input  logic [HOST_DATA_BITS-1:0]                host_req_value,
    output logic                                     host_req_deq,
    output logic                                     host_resp_valid,
    output logic [HOST_DATA_BITS-1:0]                host_resp_bits,
    output logic                                     host_wr_done,
    output logic                                     host_resp_err,
    output logic [NUM_SLAVES-1:0]                    s_axi_AWVALID,
    input  logic [NUM_SLAVES-1:0]                    s_axi_AWREADY,
    output logic [NUM_SLAVES*HOST_AXI_ADDR_BITS-1:0] s_axi_AWADDR,
    output logic [NUM_SLAVES-1:0]                    s_axi_WVALID,
    input  logic [NUM_SLAVES-1:0]                    s_axi_WREADY,
    output logic [NUM_SLAVES*HOST_AXI_DATA_BITS-1:0] s_axi_WDATA,
    output logic [NUM_SLAVES*HOST_AXI_STRB_BITS-1:0] s_axi_WSTRB,
    input  logic [NUM_SLAVES-1:0]                    s_axi_BVALID,
    output logic [NUM_SLAVES-1:0]                    s_axi_BREADY,
    input  logic [NUM_SLAVES*2-1:0]                  s_axi_BRESP,
    output logic [NUM_SLAVES-1:0]                    s_axi_ARVALID,
    input  logic [NUM_SLAVES-1:0]                    s_axi_ARREADY,
    output logic [NUM_SLAVES*HOST_AXI_ADDR_BITS-1:0] s_axi_ARADDR,
    input  logic [NUM_SLAVES-1:0]                    s_axi_RVALID,
    output logic [NUM_SLAVES-1:0]                    s_axi_RREADY,
    input  logic [NUM_SLAVES*HOST_AXI_DATA_BITS-1:0] s_axi_RDATA,
    input  logic [NUM_SLAVES*2-1:0]                  s_axi_RRESP
);

    localparam int A  = HOST_AXI_ADDR_BITS;
    localparam int DW = HOST_AXI_DATA_BITS;
    localparam int HI = HOST_ADDR_BITS - A;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_chk_ns
        $error("NUM_SLAVES must be 1..16");
    end
    if (A + SEL_BITS > HOST_ADDR_BITS) begin : g_chk_addr
        $error("address fields exceed HOST_ADDR_BITS");
    end
    if (HOST_DATA_BITS != DW) begin : g_chk_data
        $error("HOST_DATA_BITS must equal HOST_AXI_DATA_BITS");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_tmo
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR, WR_ACK, ERR
    } state_t;

    state_t                    state;
    logic [A-1:0]              addr_q;
    logic [HOST_DATA_BITS-1:0] data_q;
    logic                      opcode_q;
    logic [SEL_BITS-1:0]       sel_q;
    logic                      aw_done;
    logic                      w_done;
    logic                      resp_valid_q;
    logic                      wr_done_q;
    logic                      err_q;
    logic                      err_deq_q;
    logic [HOST_DATA_BITS-1:0] bits_q;

    logic [NUM_SLAVES-1:0] onehot;
    logic [DW-1:0]         rdata_sel;
    logic [1:0]            rresp_sel;
    logic [1:0]            bresp_sel;
    logic [HI-1:0]         req_hi;
    logic                  req_mapped;
    logic                  aw_act, w_act;
    logic                  ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
    logic                  ar_hs, aw_hs, w_hs;

    // The whole field above the AXI offset is the select, so spare
    // upper address bits also count toward an unmapped request.
    assign req_hi     = host_req_addr[HOST_ADDR_BITS-1:A];
    assign req_mapped = 32'(req_hi) < NUM_SLAVES;

    always_comb begin
        onehot    = '0;
        rdata_sel = '0;
        rresp_sel = '0;
        bresp_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            onehot[i] = (int'(sel_q) == i);
            if (onehot[i]) begin
                rdata_sel = s_axi_RDATA[i*DW +: DW];
                rresp_sel = s_axi_RRESP[2*i +: 2];
                bresp_sel = s_axi_BRESP[2*i +: 2];
            end
        end
    end

    assign aw_act = (state == WR) && !aw_done;
    assign w_act  = (state == WR) && !w_done;

    assign s_axi_ARVALID = (state == RD_ADDR) ? onehot : '0;
    assign s_axi_RREADY  = (state == RD_DATA) ? onehot : '0;
    assign s_axi_AWVALID = aw_act ? onehot : '0;
    assign s_axi_WVALID  = w_act ? onehot : '0;
    assign s_axi_BREADY  = (state == WR_ACK) ? onehot : '0;

    assign s_axi_AWADDR = {NUM_SLAVES{addr_q}};
    assign s_axi_ARADDR = {NUM_SLAVES{addr_q}};
    assign s_axi_WDATA  = {NUM_SLAVES{data_q}};
    assign s_axi_WSTRB  = '1;

    assign ar_rdy = |(s_axi_ARREADY & onehot);
    assign aw_rdy = |(s_axi_AWREADY & onehot);
    assign w_rdy  = |(s_axi_WREADY & onehot);
    assign r_vld  = |(s_axi_RVALID & onehot);
    assign b_vld  = |(s_axi_BVALID & onehot);

    assign ar_hs = (state == RD_ADDR) && ar_rdy;
    assign aw_hs = aw_act && aw_rdy;
    assign w_hs  = w_act && w_rdy;

    assign host_req_deq    = ar_hs || aw_hs || ((state == ERR) && err_deq_q);
    assign host_resp_valid = resp_valid_q || ((state == ERR) && !opcode_q);
    assign host_wr_done    = wr_done_q || ((state == ERR) && opcode_q);
    assign host_resp_err   = err_q || (state == ERR);
    assign host_resp_bits  = bits_q;

`ifdef HOST_AXI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            opcode_q     <= 1'b0;
            sel_q        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            resp_valid_q <= 1'b0;
            wr_done_q    <= 1'b0;
            err_q        <= 1'b0;
            err_deq_q    <= 1'b0;
            bits_q       <= '0;
`ifdef HOST_AXI_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            wr_done_q    <= 1'b0;
            err_q        <= 1'b0;
            err_deq_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (host_req_valid) begin
                        addr_q   <= host_req_addr[A-1:0];
                        data_q   <= host_req_value;
                        opcode_q <= host_req_opcode;
                        sel_q    <= host_req_addr[A +: SEL_BITS];
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        if (!req_mapped) begin
                            state     <= ERR;
                            err_deq_q <= 1'b1;
                            bits_q    <= '0;
                        end else begin
                            state <= host_req_opcode ? WR : RD_ADDR;
                        end
                    end
                end
                RD_ADDR: if (ar_rdy) state <= RD_DATA;
                RD_DATA: begin
                    if (r_vld) begin
                        bits_q       <= rdata_sel;
                        err_q        <= (rresp_sel >= 2'b10);
                        resp_valid_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WR: begin
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_hs;
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        state <= WR_ACK;
                end
                WR_ACK: begin
                    if (b_vld) begin
                        wr_done_q <= 1'b1;
                        err_q     <= (bresp_sel >= 2'b10);
                        state     <= IDLE;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef HOST_AXI_TIMEOUT_EN
            // Watchdog overrides whatever the FSM chose this cycle.
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1) && state != ERR) begin
                    state        <= ERR;
                    bits_q       <= '0;
                    resp_valid_q <= 1'b0;
                    wr_done_q    <= 1'b0;
                    err_q        <= 1'b0;
                    err_deq_q    <= ((state == RD_ADDR) && !ar_rdy) ||
                                    ((state == WR) && !aw_done && !aw_rdy);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_host_axi_mux.sv
// Directed self-checking bench for host_axi_mux (two slaves).
// Timeout scenario runs only when HOST_AXI_TIMEOUT_EN is defined.
module tb_host_axi_mux;

`ifdef HOST_AXI_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_opcode = 1'b0;
    logic [7:0]  host_req_addr = '0;
    logic [31:0] host_req_value = '0;
    logic        host_req_deq;
    logic        host_resp_valid;
    logic [31:0] host_resp_bits;
    logic        host_wr_done;
    logic        host_resp_err;
    logic [1:0]  s_axi_AWVALID, s_axi_WVALID, s_axi_BREADY;
    logic [1:0]  s_axi_ARVALID, s_axi_RREADY;
    logic [1:0]  s_axi_AWREADY = '0, s_axi_WREADY = '0, s_axi_BVALID = '0;
    logic [1:0]  s_axi_ARREADY = '0, s_axi_RVALID = '0;
    logic [11:0] s_axi_AWADDR, s_axi_ARADDR;
    logic [63:0] s_axi_WDATA;
    logic [7:0]  s_axi_WSTRB;
    logic [63:0] s_axi_RDATA = '0;
    logic [3:0]  s_axi_RRESP = '0, s_axi_BRESP = '0;

    int checks = 0;
    int fails  = 0;

    host_axi_mux #(.NUM_SLAVES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .host_wr_done(host_wr_done),
        .host_resp_err(host_resp_err),
        .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
        .s_axi_AWADDR(s_axi_AWADDR),
        .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
        .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB),
        .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY),
        .s_axi_BRESP(s_axi_BRESP),
        .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
        .s_axi_ARADDR(s_axi_ARADDR),
        .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY),
        .s_axi_RDATA(s_axi_RDATA), .s_axi_RRESP(s_axi_RRESP)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] v;
        reset = 1'b0;
        step();
        step();
        v = {s_axi_AWVALID, s_axi_WVALID, s_axi_BREADY, s_axi_ARVALID, s_axi_RREADY};
        checks++;
        if (v !== 10'h0) begin fails++; $display("FAIL rst_axi: got %h want 000", v); end
        checks++;
        if ({host_req_deq, host_resp_valid, host_wr_done, host_resp_err} !== 4'b0) begin
            fails++; $display("FAIL rst_host: got %b want 0000",
                {host_req_deq, host_resp_valid, host_wr_done, host_resp_err});
        end
        checks++;
        if (host_resp_bits !== 32'h0) begin fails++; $display("FAIL rst_bits: got %h want 0", host_resp_bits); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write();
        host_req_valid = 1'b1; host_req_opcode = 1'b1;
        host_req_addr = 8'h44; host_req_value = 32'hDEADBEEF;
        step();
        checks++;
        if (s_axi_AWVALID !== 2'b10 || s_axi_WVALID !== 2'b10) begin
            fails++; $display("FAIL wr_valids: got aw=%b w=%b want 10 10", s_axi_AWVALID, s_axi_WVALID);
        end
        checks++;
        if (s_axi_AWADDR[11:6] !== 6'h04) begin fails++; $display("FAIL wr_awaddr: got %h want 04", s_axi_AWADDR[11:6]); end
        checks++;
        if (s_axi_WDATA[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_wdata: got %h want deadbeef", s_axi_WDATA[63:32]); end
        checks++;
        if (s_axi_WSTRB !== 8'hFF) begin fails++; $display("FAIL wr_wstrb: got %h want ff", s_axi_WSTRB); end
        checks++;
        if (host_req_deq !== 1'b0) begin fails++; $display("FAIL wr_deq_early: got %b want 0", host_req_deq); end
        s_axi_AWREADY = 2'b10; s_axi_WREADY = 2'b10;
        #1;
        checks++;
        if (host_req_deq !== 1'b1) begin fails++; $display("FAIL wr_deq: got %b want 1", host_req_deq); end
        host_req_valid = 1'b0;
        step();
        s_axi_AWREADY = '0; s_axi_WREADY = '0;
        checks++;
        if (s_axi_BREADY !== 2'b10 || s_axi_AWVALID !== 2'b00 || host_req_deq !== 1'b0) begin
            fails++; $display("FAIL wr_ack: got bready=%b aw=%b deq=%b want 10 00 0",
                s_axi_BREADY, s_axi_AWVALID, host_req_deq);
        end
        step();
        s_axi_BVALID = 2'b10; s_axi_BRESP = 4'b0000;
        checks++;
        if (host_wr_done !== 1'b0) begin fails++; $display("FAIL wr_done_early: got %b want 0", host_wr_done); end
        step();
        s_axi_BVALID = '0;
        checks++;
        if (host_wr_done !== 1'b1 || host_resp_err !== 1'b0 || s_axi_BREADY !== 2'b00) begin
            fails++; $display("FAIL wr_done: got done=%b err=%b bready=%b want 1 0 00",
                host_wr_done, host_resp_err, s_axi_BREADY);
        end
        step();
        checks++;
        if (host_wr_done !== 1'b0) begin fails++; $display("FAIL wr_done_pulse: got %b want 0", host_wr_done); end
    endtask

    task automatic test_read();
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h10;
        step();
        checks++;
        if (s_axi_ARADDR[5:0] !== 6'h10) begin fails++; $display("FAIL rd_araddr: got %h want 10", s_axi_ARADDR[5:0]); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            checks++;
            if (s_axi_ARVALID !== 2'b01 || host_req_deq !== 1'b0) begin
                fails++; $display("FAIL rd_wait%0d: got ar=%b deq=%b want 01 0", k, s_axi_ARVALID, host_req_deq);
            end
        end
        step();
        s_axi_ARREADY = 2'b01;
        #1;
        checks++;
        if (host_req_deq !== 1'b1) begin fails++; $display("FAIL rd_deq: got %b want 1", host_req_deq); end
        host_req_valid = 1'b0;
        step();
        s_axi_ARREADY = '0;
        checks++;
        if (s_axi_RREADY !== 2'b01 || s_axi_ARVALID !== 2'b00) begin
            fails++; $display("FAIL rd_rready: got r=%b ar=%b want 01 00", s_axi_RREADY, s_axi_ARVALID);
        end
        s_axi_RVALID = 2'b01; s_axi_RDATA = {32'h0, 32'h12345678}; s_axi_RRESP = 4'b0000;
        step();
        s_axi_RVALID = '0;
        checks++;
        if (host_resp_valid !== 1'b1 || host_resp_bits !== 32'h12345678 || host_resp_err !== 1'b0) begin
            fails++; $display("FAIL rd_resp: got v=%b bits=%h err=%b want 1 12345678 0",
                host_resp_valid, host_resp_bits, host_resp_err);
        end
        step();
        checks++;
        if (host_resp_valid !== 1'b0 || host_resp_bits !== 32'h12345678) begin
            fails++; $display("FAIL rd_hold: got v=%b bits=%h want 0 12345678", host_resp_valid, host_resp_bits);
        end
    endtask

    task automatic test_w_before_aw();
        host_req_valid = 1'b1; host_req_opcode = 1'b1;
        host_req_addr = 8'h08; host_req_value = 32'hA5A50001;
        step();
        s_axi_WREADY = 2'b01;
        #1;
        checks++;
        if (host_req_deq !== 1'b0 || s_axi_WVALID !== 2'b01) begin
            fails++; $display("FAIL wfirst_w: got deq=%b w=%b want 0 01", host_req_deq, s_axi_WVALID);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            s_axi_WREADY = '0;
            checks++;
            if (s_axi_WVALID !== 2'b00 || s_axi_AWVALID !== 2'b01 || s_axi_BREADY !== 2'b00 || host_req_deq !== 1'b0) begin
                fails++; $display("FAIL wfirst_hold%0d: got w=%b aw=%b b=%b deq=%b want 00 01 00 0",
                    k, s_axi_WVALID, s_axi_AWVALID, s_axi_BREADY, host_req_deq);
            end
        end
        s_axi_AWREADY = 2'b01;
        #1;
        checks++;
        if (host_req_deq !== 1'b1) begin fails++; $display("FAIL wfirst_deq: got %b want 1", host_req_deq); end
        host_req_valid = 1'b0;
        step();
        s_axi_AWREADY = '0;
        checks++;
        if (s_axi_BREADY !== 2'b01 || s_axi_AWVALID !== 2'b00 || host_req_deq !== 1'b0) begin
            fails++; $display("FAIL wfirst_ack: got b=%b aw=%b deq=%b want 01 00 0",
                s_axi_BREADY, s_axi_AWVALID, host_req_deq);
        end
        s_axi_BVALID = 2'b01; s_axi_BRESP = 4'b0011;
        step();
        s_axi_BVALID = '0; s_axi_BRESP = '0;
        checks++;
        if (host_wr_done !== 1'b1 || host_resp_err !== 1'b1) begin
            fails++; $display("FAIL wr_slverr: got done=%b err=%b want 1 1", host_wr_done, host_resp_err);
        end
        step();
    endtask

    task automatic test_unmapped();
        logic [9:0] v;
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'hC0;
        step();
        v = {s_axi_AWVALID, s_axi_WVALID, s_axi_BREADY, s_axi_ARVALID, s_axi_RREADY};
        checks++;
        if (v !== 10'h0) begin fails++; $display("FAIL unm_axi: got %h want 000", v); end
        checks++;
        if ({host_req_deq, host_resp_valid, host_wr_done, host_resp_err} !== 4'b1101 || host_resp_bits !== 32'h0) begin
            fails++; $display("FAIL unm_rd: got deq/v/wd/err=%b bits=%h want 1101 0",
                {host_req_deq, host_resp_valid, host_wr_done, host_resp_err}, host_resp_bits);
        end
        host_req_valid = 1'b0;
        step();
        checks++;
        if (host_req_deq !== 1'b0 || host_resp_valid !== 1'b0) begin
            fails++; $display("FAIL unm_pulse: got deq=%b v=%b want 0 0", host_req_deq, host_resp_valid);
        end
        host_req_valid = 1'b1; host_req_opcode = 1'b1; host_req_addr = 8'h80;
        step();
        checks++;
        if ({host_req_deq, host_resp_valid, host_wr_done, host_resp_err} !== 4'b1011) begin
            fails++; $display("FAIL unm_wr: got deq/v/wd/err=%b want 1011",
                {host_req_deq, host_resp_valid, host_wr_done, host_resp_err});
        end
        host_req_valid = 1'b0;
        step();
    endtask

    task automatic test_read_err();
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h7F;
        step();
        checks++;
        if (s_axi_ARVALID !== 2'b10 || s_axi_ARADDR[11:6] !== 6'h3F) begin
            fails++; $display("FAIL rerr_ar: got ar=%b addr=%h want 10 3f", s_axi_ARVALID, s_axi_ARADDR[11:6]);
        end
        s_axi_ARREADY = 2'b10;
        #1;
        host_req_valid = 1'b0;
        step();
        s_axi_ARREADY = '0;
        s_axi_RVALID = 2'b10; s_axi_RDATA = {32'hCAFEF00D, 32'h0}; s_axi_RRESP = 4'b1000;
        step();
        s_axi_RVALID = '0; s_axi_RRESP = '0;
        checks++;
        if (host_resp_valid !== 1'b1 || host_resp_err !== 1'b1 || host_resp_bits !== 32'hCAFEF00D) begin
            fails++; $display("FAIL rerr_resp: got v=%b err=%b bits=%h want 1 1 cafef00d",
                host_resp_valid, host_resp_err, host_resp_bits);
        end
        step();
    endtask

    task automatic test_reset_mid();
        host_req_valid = 1'b1; host_req_opcode = 1'b1;
        host_req_addr = 8'h00; host_req_value = 32'h1;
        step();
        s_axi_AWREADY = 2'b01; s_axi_WREADY = 2'b01;
        #1;
        host_req_valid = 1'b0;
        step();
        s_axi_AWREADY = '0; s_axi_WREADY = '0;
        checks++;
        if (s_axi_BREADY !== 2'b01) begin fails++; $display("FAIL rmid_ack: got %b want 01", s_axi_BREADY); end
        reset = 1'b0;
        #1;
        checks++;
        if (s_axi_BREADY !== 2'b00 || host_resp_bits !== 32'h0 || host_wr_done !== 1'b0 || host_req_deq !== 1'b0) begin
            fails++; $display("FAIL rmid_abort: got b=%b bits=%h wd=%b deq=%b want 00 0 0 0",
                s_axi_BREADY, host_resp_bits, host_wr_done, host_req_deq);
        end
        step();
        reset = 1'b1;
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h20;
        s_axi_ARREADY = 2'b01;
        step();
        checks++;
        if (host_req_deq !== 1'b1 || s_axi_ARVALID !== 2'b01) begin
            fails++; $display("FAIL rmid_rd_deq: got deq=%b ar=%b want 1 01", host_req_deq, s_axi_ARVALID);
        end
        host_req_valid = 1'b0;
        step();
        s_axi_ARREADY = '0;
        s_axi_RVALID = 2'b01; s_axi_RDATA = {32'h0, 32'h0BADC0DE};
        step();
        s_axi_RVALID = '0;
        checks++;
        if (host_resp_valid !== 1'b1 || host_resp_bits !== 32'h0BADC0DE || host_resp_err !== 1'b0) begin
            fails++; $display("FAIL rmid_rd: got v=%b bits=%h err=%b want 1 0badc0de 0",
                host_resp_valid, host_resp_bits, host_resp_err);
        end
        step();
    endtask

`ifdef HOST_AXI_TIMEOUT_EN
    task automatic test_timeout();
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h0C;
        step();
        for (int k = 1; k < 16; k++) begin
            step();
            checks++;
            if (host_req_deq !== 1'b0 || host_resp_valid !== 1'b0 || s_axi_ARVALID !== 2'b01) begin
                fails++; $display("FAIL tmo_wait%0d: got deq=%b v=%b ar=%b want 0 0 01",
                    k, host_req_deq, host_resp_valid, s_axi_ARVALID);
            end
        end
        step();
        checks++;
        if (host_req_deq !== 1'b1 || host_resp_valid !== 1'b1 || host_resp_err !== 1'b1 ||
            host_resp_bits !== 32'h0 || s_axi_ARVALID !== 2'b00) begin
            fails++; $display("FAIL tmo_fire: got deq=%b v=%b err=%b bits=%h ar=%b want 1 1 1 0 00",
                host_req_deq, host_resp_valid, host_resp_err, host_resp_bits, s_axi_ARVALID);
        end
        host_req_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_w_before_aw();
        test_unmapped();
        test_read_err();
        test_reset_mid();
`ifdef HOST_AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
